// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage types and constants used by the PC sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'h8002_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;
  localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-state / next-PC / next-pending select for pc_sequencer.
// Exception and ERET redirects exist only when PC_EXCEPTION_EN is defined.
module pc_next_mux
  import mips_pkg::pc_state_t, mips_pkg::BOOT, mips_pkg::RUN, mips_pkg::REDIRECT;
#(
  parameter int WIDTH = 32
`ifdef PC_EXCEPTION_EN
  , parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(mips_pkg::EXC_VECTOR)
`endif
) (
  input  pc_state_t        i_state,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_pc_plus4,
  input  logic [WIDTH-1:0] i_pending,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_advance,
  input  logic             i_branch_taken,
`ifdef PC_EXCEPTION_EN
  input  logic             i_exc_req,
  input  logic             i_eret,
  input  logic [WIDTH-1:0] i_epc,
  output logic             o_exc_take,
`endif
  output pc_state_t        o_state,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pending
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_state   = i_state;
    o_pc      = i_pc;
    o_pending = i_pending;
`ifdef PC_EXCEPTION_EN
    o_exc_take = 1'b0;
`endif

    unique case (i_state)
      BOOT: o_state = RUN;
      RUN: begin
        if (i_branch_taken && i_advance) begin
          o_pc = i_target;
        end else if (i_branch_taken) begin
          o_pending = i_target;
          o_state   = REDIRECT;
        end else if (i_advance) begin
          o_pc = i_pc_plus4;
        end
      end
      REDIRECT: begin
        // A branch in the delay slot is ignored: the first target wins.
        if (i_advance) begin
          o_pc    = i_pending;
          o_state = RUN;
        end
      end
      default: o_state = BOOT;
    endcase

`ifdef PC_EXCEPTION_EN
    if (i_state != BOOT) begin
      if (i_exc_req) begin
        o_exc_take = 1'b1;
        o_pc       = EXC_VECTOR;
        o_pending  = '0;
        o_state    = RUN;
      end else if (i_eret) begin
        o_pc    = i_epc;
        o_state = RUN;
      end
    end
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage (boot, sequential, stall, delayed branch).
// Define PC_EXCEPTION_EN to add the exception entry / ERET path with epc and exc_bd.
module pc_sequencer
  import mips_pkg::pc_state_t, mips_pkg::BOOT, mips_pkg::RUN, mips_pkg::REDIRECT,
         mips_pkg::PC_INCR;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(mips_pkg::RESET_VECTOR)
`ifdef PC_EXCEPTION_EN
  , parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(mips_pkg::EXC_VECTOR)
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
`ifdef PC_EXCEPTION_EN
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] epc,
  output logic             exc_bd,
`endif
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             in_delay_slot
);

  pc_state_t        r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pending;

  pc_state_t        w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_target;
  logic             w_advance;

  assign w_target      = branch_target & ~WIDTH'(3);
  assign pc_out        = r_pc;
  assign pc_plus4      = r_pc + WIDTH'(PC_INCR);
  assign fetch_valid   = (r_state != BOOT);
  assign w_advance     = fetch_valid & imem_ready & ~stall;
  assign in_delay_slot = ((r_state == RUN) & branch_taken) | (r_state == REDIRECT);

`ifdef PC_EXCEPTION_EN
  logic             w_exc_take;
  logic [WIDTH-1:0] r_epc;
  logic             r_exc_bd;

  assign epc    = r_epc;
  assign exc_bd = r_exc_bd;
`endif

  pc_next_mux #(
    .WIDTH      (WIDTH)
`ifdef PC_EXCEPTION_EN
    , .EXC_VECTOR (EXC_VECTOR)
`endif
  ) u_next_mux (
    .i_state        (r_state),
    .i_pc           (r_pc),
    .i_pc_plus4     (pc_plus4),
    .i_pending      (r_pending),
    .i_target       (w_target),
    .i_advance      (w_advance),
    .i_branch_taken (branch_taken),
`ifdef PC_EXCEPTION_EN
    .i_exc_req      (exc_req),
    .i_eret         (eret),
    .i_epc          (r_epc),
    .o_exc_take     (w_exc_take),
`endif
    .o_state        (w_state_nxt),
    .o_pc           (w_pc_nxt),
    .o_pending      (w_pending_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VECTOR;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pending <= w_pending_nxt;
    end
  end

`ifdef PC_EXCEPTION_EN
  // A faulting delay-slot instruction restarts at its branch, one word earlier.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_epc    <= '0;
      r_exc_bd <= 1'b0;
    end else if (w_exc_take) begin
      r_epc    <= in_delay_slot ? (r_pc - WIDTH'(PC_INCR)) : r_pc;
      r_exc_bd <= in_delay_slot;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected PC/state per cycle is queued
// as stimulus is driven and compared after the clock edge.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        in_delay_slot;
`ifdef PC_EXCEPTION_EN
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc;
  logic        exc_bd;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        ids;
  } exp_t;

  exp_t sb[$];

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef PC_EXCEPTION_EN
    .exc_req       (exc_req),
    .eret          (eret),
    .epc           (epc),
    .exc_bd        (exc_bd),
`endif
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .in_delay_slot (in_delay_slot)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare
  // with the single-cycle pulse inputs released.
  task automatic step(input string tag, input logic rst, input logic st, input logic rdy,
                      input logic bt, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic e_fv, input logic e_ids);
    exp_t e;
    reset         = rst;
    stall         = st;
    imem_ready    = rdy;
    branch_taken  = bt;
    branch_target = tgt;
    sb.push_back('{tag, e_pc, e_fv, e_ids});
    @(posedge clock);
    #1;
    branch_taken = 1'b0;
`ifdef PC_EXCEPTION_EN
    exc_req = 1'b0;
    eret    = 1'b0;
`endif
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"},  pc_out,              e.pc);
    check({e.tag, ".fv"},  32'(fetch_valid),    32'(e.fv));
    check({e.tag, ".ids"}, 32'(in_delay_slot),  32'(e.ids));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles, then BOOT, then fetching.
    step("rst0", 1, 0, 0, 0, 32'h0, 32'h8002_0000, 0, 0);
    step("rst1", 1, 0, 1, 0, 32'h0, 32'h8002_0000, 0, 0);
    check("boot_plus4", pc_plus4, 32'h8002_0004);
    step("boot", 0, 0, 1, 1, 32'h1234_0000, 32'h8002_0000, 1, 0);

    // Sequential fetch with a four-cycle stall at 80020008.
    step("seq1", 0, 0, 1, 0, 32'h0, 32'h8002_0004, 1, 0);
    step("seq2", 0, 0, 1, 0, 32'h0, 32'h8002_0008, 1, 0);
    for (int i = 0; i < 4; i++)
      step("stall", 0, 1, 1, 0, 32'h0, 32'h8002_0008, 1, 0);
    step("seq3", 0, 0, 1, 0, 32'h0, 32'h8002_000C, 1, 0);
    step("seq4", 0, 0, 1, 0, 32'h0, 32'h8002_0010, 1, 0);

    // Taken branch while memory not ready: wait in REDIRECT, second branch ignored.
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h8002_0100;
    #1;
    check("ids_comb", 32'(in_delay_slot), 32'h1);
    step("br_wait", 0, 0, 0, 1, 32'h8002_0100, 32'h8002_0010, 1, 1);
    step("br_ign",  0, 0, 0, 1, 32'h8002_0200, 32'h8002_0010, 1, 1);
    step("br_go",   0, 0, 1, 0, 32'h0,         32'h8002_0100, 1, 0);

    // Branch taken with advance, target alignment forced.
    step("seq5",   0, 0, 1, 0, 32'h0,         32'h8002_0104, 1, 0);
    step("br_aln", 0, 0, 1, 1, 32'h8002_0103, 32'h8002_0100, 1, 0);

    // Stall beats imem_ready on a branch; then wrap at top of address space.
    step("br_stl", 0, 1, 1, 1, 32'hFFFF_FFFE, 32'h8002_0100, 1, 1);
    step("br_top", 0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 1, 0);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    step("wrap",   0, 0, 1, 0, 32'h0,         32'h0000_0000, 1, 0);

    // Reset while a redirect is pending drops the pending target.
    step("pend",   0, 0, 0, 1, 32'h1234_5678, 32'h0000_0000, 1, 1);
    step("rst2",   1, 0, 0, 0, 32'h0,         32'h8002_0000, 0, 0);
    step("boot2",  0, 0, 1, 0, 32'h0,         32'h8002_0000, 1, 0);
    step("seq6",   0, 0, 1, 0, 32'h0,         32'h8002_0004, 1, 0);

`ifdef PC_EXCEPTION_EN
    step("seq7",  0, 0, 1, 0, 32'h0,         32'h8002_0008, 1, 0);
    step("seq8",  0, 0, 1, 0, 32'h0,         32'h8002_000C, 1, 0);
    step("seq9",  0, 0, 1, 0, 32'h0,         32'h8002_0010, 1, 0);
    step("seq10", 0, 0, 1, 0, 32'h0,         32'h8002_0014, 1, 0);
    step("br_x",  0, 0, 0, 1, 32'h8002_0400, 32'h8002_0014, 1, 1);
    exc_req = 1'b1;
    step("exc",   0, 1, 0, 0, 32'h0,         32'h8000_0180, 1, 0);
    check("epc",    epc,          32'h8002_0010);
    check("exc_bd", 32'(exc_bd),  32'h1);
    eret = 1'b1;
    step("eret",  0, 0, 0, 0, 32'h0,         32'h8002_0010, 1, 0);
    check("epc_hold", epc, 32'h8002_0010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
